// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: clear sequencer > core write-back > debug writes.
// Optional debug wait statistics counter enabled by defining RF_ARB_WAIT_CNT_EN.
module regfile_write_arbiter #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dir,
    input  logic [DATA_W-1:0] wb_data,
    output logic              core_stall,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_dir,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dir,
    output logic [DATA_W-1:0] rf_data,
    output logic [CNT_W-1:0]  dbg_wait_cnt
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_t            state, nextState;
    logic [ADDR_W-1:0] clrIdx;
    logic              weNext;
    logic [ADDR_W-1:0] dirNext;
    logic [DATA_W-1:0] dataNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (clr_start) nextState = CLEAR;
            CLEAR:   if (clrIdx == LAST_IDX) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Writes to register 0 are handshaken but never reach the register file.
    always_comb begin
        clr_busy   = (state == CLEAR) || (state == DONE);
        core_stall = clr_busy;
        dbg_ready  = rst && (state == IDLE) && !wb_en && !clr_start;
        weNext     = 1'b0;
        dirNext    = rf_dir;
        dataNext   = rf_data;
        if (state == CLEAR) begin
            weNext   = 1'b1;
            dirNext  = clrIdx;
            dataNext = '0;
        end else if (state == IDLE && wb_en) begin
            if (wb_dir != '0) begin
                weNext   = 1'b1;
                dirNext  = wb_dir;
                dataNext = wb_data;
            end
        end else if (dbg_valid && dbg_ready) begin
            if (dbg_dir != '0) begin
                weNext   = 1'b1;
                dirNext  = dbg_dir;
                dataNext = dbg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clrIdx   <= FIRST_IDX;
            rf_we    <= 1'b0;
            rf_dir   <= '0;
            rf_data  <= '0;
            clr_done <= 1'b0;
        end else begin
            clrIdx   <= (state == CLEAR) ? clrIdx + FIRST_IDX : FIRST_IDX;
            rf_we    <= weNext;
            rf_dir   <= dirNext;
            rf_data  <= dataNext;
            clr_done <= (state == DONE);
        end
    end

`ifdef RF_ARB_WAIT_CNT_EN
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] waitCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         waitCnt <= '0;
        else if (dbg_valid && !dbg_ready) waitCnt <= satInc(waitCnt);
    end

    assign dbg_wait_cnt = waitCnt;
`else
    assign dbg_wait_cnt = '0;
`endif

endmodule
